// File: rtl/cfg_router_if.sv
// Packet-side bus of the config router: request in, reply/error packet out.
interface cfg_router_if;
  logic [95:0] pkt_in;
  logic        pkt_in_valid;
  logic [95:0] pkt_out;
  logic        pkt_out_valid;

  modport master (output pkt_in, pkt_in_valid, input pkt_out, pkt_out_valid);
  modport slave  (input pkt_in, pkt_in_valid, output pkt_out, pkt_out_valid);
endinterface

// File: rtl/cfg_router.sv
// Routes 96-bit config request packets to one of NUM_SLAVES register slaves and returns a reply.
// Optional sack timeout is built only when CFG_ROUTER_SACK_TIMEOUT_EN is defined.
module cfg_router #(
  parameter int NUM_SLAVES     = 6,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                     clock,
  input  logic                     reset,
  cfg_router_if.slave              pkt,
  input  logic                     any_error,
  input  logic [NUM_SLAVES-1:0]    cfg_sack,
  output logic [NUM_SLAVES-1:0]    cfg_mread_en,
  output logic [NUM_SLAVES-1:0]    cfg_mwrite_en,
  output logic [7:0]               cfg_addr,
  output logic [31:0]              cfg_data_mwrite,
  input  logic [32*NUM_SLAVES-1:0] cfg_data_mread,
  output logic                     busy,
  output logic                     req_dropped
);

  typedef enum logic {IDLE, WAIT} state_t;

  localparam logic [8:0] NUM_SLAVES_W = 9'(NUM_SLAVES);

  state_t                state_q, state_d;
  logic [NUM_SLAVES-1:0] rd_en_q, rd_en_d, wr_en_q, wr_en_d;
  logic [7:0]            addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [95:0]           pkt_out_q, pkt_out_d;
  logic                  pkt_out_valid_q, pkt_out_valid_d;
  logic                  req_dropped_q, req_dropped_d;
  logic [7:0]            magic_q, magic_d, version_q, version_d, mod_q, mod_d;
  logic [6:0]            flags_q, flags_d;
  logic [15:0]           id_q, id_d;

  logic [7:0]            in_magic, in_type, in_mod, in_addr;
  logic [15:0]           in_id;
  logic [NUM_SLAVES-1:0] in_sel, en_any;
  logic [31:0]           rd_data;
  logic                  sack_hit;
  logic                  unused_flag7;

  assign in_magic     = pkt.pkt_in[95:88];
  assign in_type      = pkt.pkt_in[79:72];
  assign in_id        = pkt.pkt_in[63:48];
  assign in_mod       = pkt.pkt_in[47:40];
  assign in_addr      = pkt.pkt_in[39:32];
  assign unused_flag7 = pkt.pkt_in[71];

  function automatic logic [95:0] err_pkt(input logic [15:0] id, input logic [7:0] md,
                                          input logic [7:0] ad, input logic [7:0] code);
    return {8'h5A, 8'h00, 8'h7F, 8'h80, id, md, ad, 24'd0, code};
  endfunction

`ifdef CFG_ROUTER_SACK_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
`endif

  // The enable vectors are one-hot on the selected slave, so they double as the sack/data select.
  always_comb begin
    en_any   = rd_en_q | wr_en_q;
    sack_hit = |(cfg_sack & en_any);
    rd_data  = '0;
    in_sel   = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (en_any[k]) rd_data = rd_data | cfg_data_mread[32*k +: 32];
      in_sel[k] = (in_mod == 8'(k));
    end
  end

  always_comb begin
    state_d         = state_q;
    rd_en_d         = rd_en_q;
    wr_en_d         = wr_en_q;
    addr_d          = addr_q;
    wdata_d         = wdata_q;
    pkt_out_d       = pkt_out_q;
    pkt_out_valid_d = 1'b0;
    req_dropped_d   = req_dropped_q;
    magic_d         = magic_q;
    version_d       = version_q;
    flags_d         = flags_q;
    id_d            = id_q;
    mod_d           = mod_q;
`ifdef CFG_ROUTER_SACK_TIMEOUT_EN
    cnt_d           = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (pkt.pkt_in_valid) begin
          if (in_magic != 8'h5A) begin
            pkt_out_d       = err_pkt(in_id, in_mod, in_addr, 8'h01);
            pkt_out_valid_d = 1'b1;
          end else if (in_type != 8'h01) begin
            pkt_out_d       = err_pkt(in_id, in_mod, in_addr, 8'h02);
            pkt_out_valid_d = 1'b1;
          end else if ({1'b0, in_mod} >= NUM_SLAVES_W) begin
            pkt_out_d       = err_pkt(in_id, in_mod, in_addr, 8'h03);
            pkt_out_valid_d = 1'b1;
          end else begin
            state_d   = WAIT;
            magic_d   = in_magic;
            version_d = pkt.pkt_in[87:80];
            flags_d   = pkt.pkt_in[70:64];
            id_d      = in_id;
            mod_d     = in_mod;
            addr_d    = in_addr;
            if (pkt.pkt_in[64]) begin
              wr_en_d = in_sel;
              wdata_d = pkt.pkt_in[31:0];
            end else begin
              rd_en_d = in_sel;
            end
`ifdef CFG_ROUTER_SACK_TIMEOUT_EN
            cnt_d = '0;
`endif
          end
        end
      end
      WAIT: begin
        if (pkt.pkt_in_valid) req_dropped_d = 1'b1;
        if (sack_hit) begin
          state_d         = IDLE;
          rd_en_d         = '0;
          wr_en_d         = '0;
          pkt_out_d       = {magic_q, version_q, 8'h02, any_error, flags_q, id_q, mod_q,
                             addr_q, rd_data};
          pkt_out_valid_d = 1'b1;
        end
`ifdef CFG_ROUTER_SACK_TIMEOUT_EN
        else if (cnt_q + 16'd1 == 16'(TIMEOUT_CYCLES)) begin
          state_d         = IDLE;
          rd_en_d         = '0;
          wr_en_d         = '0;
          pkt_out_d       = err_pkt(id_q, mod_q, addr_q, 8'h04);
          pkt_out_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= IDLE;
      rd_en_q         <= '0;
      wr_en_q         <= '0;
      addr_q          <= '0;
      wdata_q         <= '0;
      pkt_out_q       <= '0;
      pkt_out_valid_q <= 1'b0;
      req_dropped_q   <= 1'b0;
      magic_q         <= '0;
      version_q       <= '0;
      flags_q         <= '0;
      id_q            <= '0;
      mod_q           <= '0;
`ifdef CFG_ROUTER_SACK_TIMEOUT_EN
      cnt_q           <= '0;
`endif
    end else begin
      state_q         <= state_d;
      rd_en_q         <= rd_en_d;
      wr_en_q         <= wr_en_d;
      addr_q          <= addr_d;
      wdata_q         <= wdata_d;
      pkt_out_q       <= pkt_out_d;
      pkt_out_valid_q <= pkt_out_valid_d;
      req_dropped_q   <= req_dropped_d;
      magic_q         <= magic_d;
      version_q       <= version_d;
      flags_q         <= flags_d;
      id_q            <= id_d;
      mod_q           <= mod_d;
`ifdef CFG_ROUTER_SACK_TIMEOUT_EN
      cnt_q           <= cnt_d;
`endif
    end
  end

  assign pkt.pkt_out       = pkt_out_q;
  assign pkt.pkt_out_valid = pkt_out_valid_q;
  assign cfg_mread_en      = rd_en_q;
  assign cfg_mwrite_en     = wr_en_q;
  assign cfg_addr          = addr_q;
  assign cfg_data_mwrite   = wdata_q;
  assign busy              = (state_q != IDLE);
  assign req_dropped       = req_dropped_q;

endmodule

// File: tb/tb_cfg_router.sv
// Directed bench for cfg_router: expected replies queued at stimulus time, checked by a reply monitor.
module tb_cfg_router;
  localparam int NS = 6;
  localparam int TO = 8;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  cfg_router_if pkt ();
  logic              any_error;
  logic [NS-1:0]     cfg_sack, cfg_mread_en, cfg_mwrite_en;
  logic [7:0]        cfg_addr;
  logic [31:0]       cfg_data_mwrite;
  logic [32*NS-1:0]  cfg_data_mread;
  logic              busy, req_dropped;

  cfg_router #(.NUM_SLAVES(NS), .TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset(reset), .pkt(pkt),
    .any_error(any_error), .cfg_sack(cfg_sack),
    .cfg_mread_en(cfg_mread_en), .cfg_mwrite_en(cfg_mwrite_en),
    .cfg_addr(cfg_addr), .cfg_data_mwrite(cfg_data_mwrite),
    .cfg_data_mread(cfg_data_mread), .busy(busy), .req_dropped(req_dropped)
  );

  int          n_vec = 0;
  int          n_err = 0;
  logic [95:0] exp_q[$];

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reply monitor: every pkt_out_valid strobe must match the oldest queued expectation.
  always @(negedge clock) begin
    if (pkt.pkt_out_valid === 1'b1) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_reply: got %h expected no reply", pkt.pkt_out);
      end else begin
        logic [95:0] e;
        e = exp_q.pop_front();
        if (pkt.pkt_out !== e) begin
          n_err++;
          $display("FAIL reply: got %h expected %h", pkt.pkt_out, e);
        end
      end
    end
  end

  function automatic logic [95:0] err_pkt(input logic [15:0] id, input logic [7:0] md,
                                          input logic [7:0] ad, input logic [7:0] code);
    return {8'h5A, 8'h00, 8'h7F, 8'h80, id, md, ad, 24'd0, code};
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Request is held for one cycle, then pkt_in is scrambled to prove fields were latched.
  task automatic send(input logic [95:0] p);
    pkt.pkt_in       = p;
    pkt.pkt_in_valid = 1'b1;
    step();
    pkt.pkt_in_valid = 1'b0;
    pkt.pkt_in       = ~p;
  endtask

  task automatic run_txn(input logic [95:0] p, input int lat, input logic [NS-1:0] exp_w,
                         input logic [NS-1:0] exp_r, input logic [95:0] reply);
    send(p);
    chk("cfg_addr", cfg_addr, p[39:32]);
    for (int i = 0; i < lat; i++) begin
      chk("mwrite_en", cfg_mwrite_en, exp_w);
      chk("mread_en", cfg_mread_en, exp_r);
      chk("busy_wait", busy, 1);
      if (i == lat - 1) begin
        cfg_sack = exp_w | exp_r;
        exp_q.push_back(reply);
      end
      step();
    end
    cfg_sack = '0;
    chk("mwrite_en_done", cfg_mwrite_en, 0);
    chk("mread_en_done", cfg_mread_en, 0);
    chk("busy_done", busy, 0);
  endtask

  initial begin
    logic [95:0] p;
    reset            = 1'b1;
    any_error        = 1'b0;
    cfg_sack         = '0;
    pkt.pkt_in       = '0;
    pkt.pkt_in_valid = 1'b0;
    for (int k = 0; k < NS; k++) cfg_data_mread[32*k +: 32] = 32'hCAFE0000 + 32'(k);
    cfg_data_mread[32*5 +: 32] = 32'h12345678;
    step();
    step();
    reset = 1'b0;
    chk("rst_pkt_out", pkt.pkt_out, 0);
    chk("rst_valid", pkt.pkt_out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_en", {cfg_mread_en, cfg_mwrite_en}, 0);
    chk("rst_addr_data", {cfg_addr, cfg_data_mwrite}, 0);
    chk("rst_dropped", req_dropped, 0);

    // Write to slave 2, ack after 3 cycles
    p = {8'h5A, 8'h01, 8'h01, 8'h01, 16'h1234, 8'h02, 8'h10, 32'hDEADBEEF};
    run_txn(p, 3, 6'b000100, 6'b000000,
            {8'h5A, 8'h01, 8'h02, 8'h01, 16'h1234, 8'h02, 8'h10, 32'hCAFE0002});
    chk("wdata", cfg_data_mwrite, 32'hDEADBEEF);

    // Back-to-back read from slave 5 with any_error set; write data must not move
    any_error = 1'b1;
    p = {8'h5A, 8'h03, 8'h01, 8'h40, 16'hBEEF, 8'h05, 8'h22, 32'h99999999};
    run_txn(p, 1, 6'b000000, 6'b100000,
            {8'h5A, 8'h03, 8'h02, 8'hC0, 16'hBEEF, 8'h05, 8'h22, 32'h12345678});
    any_error = 1'b0;
    chk("wdata_after_read", cfg_data_mwrite, 32'hDEADBEEF);

    // Validation errors: module out of range, bad magic, bad type, bad magic+type
    exp_q.push_back(err_pkt(16'h0A0A, 8'h06, 8'h33, 8'h03));
    send({8'h5A, 8'h01, 8'h01, 8'h01, 16'h0A0A, 8'h06, 8'h33, 32'h1});
    chk("err_mod_en", {cfg_mread_en, cfg_mwrite_en}, 0);
    chk("err_mod_busy", busy, 0);
    exp_q.push_back(err_pkt(16'h0B0B, 8'h02, 8'h44, 8'h01));
    send({8'h00, 8'h01, 8'h01, 8'h00, 16'h0B0B, 8'h02, 8'h44, 32'h2});
    chk("err_magic_en", {cfg_mread_en, cfg_mwrite_en}, 0);
    exp_q.push_back(err_pkt(16'h0C0C, 8'h01, 8'h55, 8'h02));
    send({8'h5A, 8'h01, 8'h05, 8'h00, 16'h0C0C, 8'h01, 8'h55, 32'h3});
    exp_q.push_back(err_pkt(16'h0C0D, 8'hFF, 8'h56, 8'h01));
    send({8'h11, 8'h01, 8'h07, 8'h00, 16'h0C0D, 8'hFF, 8'h56, 32'h4});
    chk("err_busy", busy, 0);
    step();

    // Sack while idle is ignored
    cfg_sack = '1;
    step();
    cfg_sack = '0;
    chk("idle_sack_busy", busy, 0);

    // Read from slave 0, second strobe while waiting, plus sacks from other slaves
    send({8'h5A, 8'h02, 8'h01, 8'h00, 16'h0D0D, 8'h00, 8'h66, 32'h0});
    chk("dropped_before", req_dropped, 0);
    chk("rd0_en", cfg_mread_en, 6'b000001);
    pkt.pkt_in       = {8'h5A, 8'h01, 8'h01, 8'h01, 16'h7777, 8'h01, 8'h99, 32'h5};
    pkt.pkt_in_valid = 1'b1;
    cfg_sack         = 6'b111110;
    step();
    pkt.pkt_in_valid = 1'b0;
    cfg_sack         = '0;
    chk("dropped_set", req_dropped, 1);
    chk("rd0_en_held", cfg_mread_en, 6'b000001);
    chk("rd0_wr_en", cfg_mwrite_en, 0);
    chk("rd0_busy", busy, 1);
    cfg_sack = 6'b000001;
    exp_q.push_back({8'h5A, 8'h02, 8'h02, 8'h00, 16'h0D0D, 8'h00, 8'h66, 32'hCAFE0000});
    step();
    cfg_sack = '0;
    chk("rd0_done_en", cfg_mread_en, 0);
    chk("dropped_sticky", req_dropped, 1);
    repeat (3) step();

`ifdef CFG_ROUTER_SACK_TIMEOUT_EN
    // Slave 3 never acks: enable high for exactly TO wait cycles, then code 0x04
    send({8'h5A, 8'h00, 8'h01, 8'h00, 16'h0F0F, 8'h03, 8'h88, 32'h0});
    for (int i = 0; i < TO; i++) begin
      chk("to_en", cfg_mread_en, 6'b001000);
      if (i == TO - 1) exp_q.push_back(err_pkt(16'h0F0F, 8'h03, 8'h88, 8'h04));
      step();
    end
    chk("to_en_done", cfg_mread_en, 0);
    chk("to_busy", busy, 0);
`else
    // Without the timeout the wait outlasts TO cycles and still completes on sack
    send({8'h5A, 8'h00, 8'h01, 8'h00, 16'h0F0F, 8'h03, 8'h88, 32'h0});
    repeat (3 * TO) step();
    chk("no_to_en", cfg_mread_en, 6'b001000);
    chk("no_to_busy", busy, 1);
    cfg_sack = 6'b001000;
    exp_q.push_back({8'h5A, 8'h00, 8'h02, 8'h00, 16'h0F0F, 8'h03, 8'h88, 32'hCAFE0003});
    step();
    cfg_sack = '0;
    chk("no_to_done", busy, 0);
`endif
    step();

    // Reset in the middle of a write wait: no reply, everything back to reset values
    send({8'h5A, 8'h01, 8'h01, 8'h01, 16'h0E0E, 8'h01, 8'h77, 32'h11112222});
    chk("mid_en", cfg_mwrite_en, 6'b000010);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mrst_en", {cfg_mread_en, cfg_mwrite_en}, 0);
    chk("mrst_addr_data", {cfg_addr, cfg_data_mwrite}, 0);
    chk("mrst_pkt_out", pkt.pkt_out, 0);
    chk("mrst_valid", pkt.pkt_out_valid, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_dropped", req_dropped, 0);
    cfg_sack = 6'b000010;
    step();
    cfg_sack = '0;
    repeat (3) step();
    chk("replies_pending", 96'(exp_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
